serial_ripple_subtractor: RTL and testbench

Bit-serial subtractor computing `a - b - borrow_in` one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop. It is the subtracting counterpart of the team's ripple-carry adders: the same bit-by-bit borrow ripple, unrolled in time instead of space. It sits beside the adders in the arithmetic library and serves area-constrained datapaths that accept multi-cycle latency. A start/busy/done handshake connects it to a controlling FSM.

---
 rtl/serial_ripple_subtractor.sv | 79 +++++++
 tb/tb_serial_ripple_subtractor.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/serial_ripple_subtractor.sv
// serial_ripple_subtractor: bit-serial a - b - borrow_in, LSB first, one full-subtractor cell.
// Optional signed overflow flag with SUB_OVERFLOW_EN.
module serial_ripple_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             busy,
    output logic             done
`ifdef SUB_OVERFLOW_EN
    ,output logic            overflow
`endif
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] CALC = 1'b1;
    logic [0:0]       state;
    logic [WIDTH-1:0] a_sr, b_sr, d_sr;
    logic [CW-1:0]    cnt;
    logic             br, ai, bi, d, br_nxt, last;
    assign ai     = a_sr[0];
    assign bi     = b_sr[0];
    assign d      = ai ^ bi ^ br;
    assign br_nxt = (~ai & bi) | (~(ai ^ bi) & br);
    assign last   = cnt == CW'(WIDTH - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            a_sr       <= '0;
            b_sr       <= '0;
            d_sr       <= '0;
            cnt        <= '0;
            br         <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            overflow   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    a_sr  <= a;
                    b_sr  <= b;
                    br    <= borrow_in;
                    cnt   <= '0;
                    state <= CALC;
                    busy  <= 1'b1;
                end
            end else begin
                a_sr <= a_sr >> 1;
                b_sr <= b_sr >> 1;
                d_sr <= {d, d_sr[WIDTH-1:1]};
                br   <= br_nxt;
                if (last) begin
                    diff       <= {d, d_sr[WIDTH-1:1]};
                    borrow_out <= br_nxt;
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
`ifdef SUB_OVERFLOW_EN
                    // on the last bit ai/bi are the operand sign bits and d is the result sign
                    overflow   <= (ai ^ bi) & (d ^ ai);
`endif
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// tb_serial_ripple_subtractor: scoreboard bench for serial_ripple_subtractor (WIDTH=4).
module tb_serial_ripple_subtractor;
    localparam int W = 4;
    logic         clk = 1'b0, rst = 1'b1, start = 1'b0, borrow_in = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic [W-1:0] diff;
    logic         borrow_out, busy, done;
`ifdef SUB_OVERFLOW_EN
    logic         overflow;
`endif
    serial_ripple_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .borrow_in(borrow_in),
        .diff(diff), .borrow_out(borrow_out), .busy(busy), .done(done)
`ifdef SUB_OVERFLOW_EN
        , .overflow(overflow)
`endif
    );
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;
    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
        int           e0;
    } exp_t;
    exp_t q[$];
    int checks = 0, errs = 0;
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", n, act, req);
        end
    endtask
    task automatic issue(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xbin,
                         input logic [W-1:0] ed, input logic ebo);
        exp_t e;
        @(negedge clk);
        a = xa; b = xb; borrow_in = xbin; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        e.d  = ed;
        e.bo = ebo;
        e.ov = (xa[W-1] != xb[W-1]) && (ed[W-1] != xa[W-1]);
        e.e0 = cyc;
        q.push_back(e);
    endtask
    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 20) begin
            @(negedge clk);
            #1 n++;
        end
        if (q.size() != 0) begin
            checks++;
            errs++;
            $display("FAIL drain: %0d results still pending after timeout", q.size());
            q.delete();
        end
    endtask
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (q.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL unexpected_done: done=1 with no pending operation");
            end else begin
                e = q.pop_front();
                chk("diff", diff, e.d);
                chk("borrow_out", borrow_out, e.bo);
                chk("latency", cyc - e.e0, W);
                chk("busy_at_done", busy, 0);
`ifdef SUB_OVERFLOW_EN
                chk("overflow", overflow, e.ov);
`endif
            end
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        logic [W:0] r;
        #12;
        chk("rst_diff", diff, 0);
        chk("rst_borrow", borrow_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk) rst = 1'b0;
        issue(4'd9, 4'd3, 1'b0, 4'd6, 1'b0);
        chk("busy_after_start", busy, 1);
        drain();
        issue(4'd3, 4'd6, 1'b0, 4'd13, 1'b1);
        drain();
        issue(4'd0, 4'd0, 1'b1, 4'd15, 1'b1);
        drain();
        // a start two cycles into an operation must be ignored; one in the done cycle is taken
        issue(4'd9, 4'd3, 1'b0, 4'd6, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        a = 4'd5; b = 4'd1; borrow_in = 1'b0; start = 1'b1;
        chk("busy_mid", busy, 1);
        chk("diff_hold", diff, 15);
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        issue(4'd7, 4'd2, 1'b0, 4'd5, 1'b0);
        chk("busy_b2b", busy, 1);
        drain();
        issue(4'd12, 4'd4, 1'b0, 4'd8, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_diff", diff, 0);
        chk("abort_borrow", borrow_out, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        q.delete();
        @(negedge clk) rst = 1'b0;
        repeat (8) @(posedge clk);
        issue(4'd12, 4'd4, 1'b0, 4'd8, 1'b0);
        drain();
`ifdef SUB_OVERFLOW_EN
        issue(4'd8, 4'd1, 1'b0, 4'd7, 1'b0);
        drain();
        chk("ovf_set", overflow, 1);
        issue(4'd2, 4'd1, 1'b0, 4'd1, 1'b0);
        drain();
        chk("ovf_clear", overflow, 0);
`endif
        for (int ia = 0; ia < 16; ia++)
            for (int ib = 0; ib < 16; ib++)
                for (int bn = 0; bn < 2; bn++) begin
                    r = {1'b0, 4'(ia)} - {1'b0, 4'(ib)} - 5'(bn);
                    issue(4'(ia), 4'(ib), 1'(bn), r[W-1:0], r[W]);
                    repeat (W) @(posedge clk);
                end
        drain();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
